// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared PE command/state encodings and controller FSM states
package pe_ctrl_pkg;

  localparam int PE_CMD_BITS   = 2;
  localparam int PE_STATE_BITS = 1;

  localparam logic [PE_CMD_BITS-1:0] PE_CMD_NOP     = 2'd0;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_PROCESS = 2'd1;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_WRITE   = 2'd2;

  localparam logic [PE_STATE_BITS-1:0] PE_DEAD = 1'b0;
  localparam logic [PE_STATE_BITS-1:0] PE_LIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_SCAN  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pe_onehot_dec.sv
// rtl/pe_onehot_dec.sv - index to one-hot decoder, all-zero when disabled or out of range
module pe_onehot_dec #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (idx == W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - Life PE array sequencer: cell writes, generation runs, raster readout
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PE_CMD_BITS-1:0]   cmd,
  output logic [ROWS-1:0]          rsel_i,
  output logic [COLS-1:0]          csel_i,
  output logic [ROWS-1:0]          rsel_o,
  output logic [COLS-1:0]          csel_o,
  input  logic                     array_active,
  input  logic [PE_STATE_BITS-1:0] array_state,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [RW-1:0]            wr_row,
  input  logic [CW-1:0]            wr_col,
  input  logic [PE_STATE_BITS-1:0] wr_state,
  input  logic                     run_start,
  input  logic [GEN_W-1:0]         run_gens,
  output logic                     run_busy,
  output logic                     run_done,
  output logic                     stable,
  output logic [GEN_W-1:0]         gen_count,
  input  logic                     rd_start,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [PE_STATE_BITS-1:0] rd_data,
  output logic [RW-1:0]            rd_row,
  output logic [CW-1:0]            rd_col,
  output logic                     rd_last
);

  ctrl_state_e              state_q, state_d;
  logic [PE_CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [ROWS-1:0]          rsel_i_q, rsel_i_d, rsel_o_q, rsel_o_d;
  logic [COLS-1:0]          csel_i_q, csel_i_d, csel_o_q, csel_o_d;
  logic [GEN_W-1:0]         gens_q, gens_d;
  logic [GEN_W-1:0]         gen_count_q, gen_count_d;
  logic                     run_busy_q, run_busy_d;
  logic                     run_done_q, run_done_d;
  logic                     stable_q, stable_d;
  logic                     rd_last_q, rd_last_d;
  logic [RW-1:0]            rd_row_q, rd_row_d;
  logic [CW-1:0]            rd_col_q, rd_col_d;
  logic                     wr_en, rd_en;
  logic [GEN_W:0]           gen_next;
  logic                     limit_hit;

  // The cell value reaches the PEs straight from the host via the array top.
  logic unused_wr_state;
  assign unused_wr_state = ^wr_state;

  always_comb begin
    state_d     = state_q;
    cmd_d       = PE_CMD_NOP;
    run_busy_d  = 1'b0;
    run_done_d  = 1'b0;
    stable_d    = stable_q;
    gens_d      = gens_q;
    gen_count_d = gen_count_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    rd_last_d   = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_ready    = 1'b0;
    gen_next    = {1'b0, gen_count_q} + (GEN_W+1)'(1);
    limit_hit   = (gens_q != '0) && (gen_next == {1'b0, gens_q});

    case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          state_d = ST_WRITE;
          cmd_d   = PE_CMD_WRITE;
          wr_en   = 1'b1;
        end else if (run_start) begin
          state_d     = ST_RUN;
          cmd_d       = PE_CMD_PROCESS;
          run_busy_d  = 1'b1;
          gens_d      = run_gens;
          gen_count_d = '0;
          stable_d    = 1'b0;
        end else if (rd_start) begin
          state_d  = ST_SCAN;
          rd_row_d = '0;
          rd_col_d = '0;
          rd_en    = 1'b1;
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      ST_RUN: begin
        // Saturate: the carry out is only set when the counter is already all-ones.
        gen_count_d = gen_next[GEN_W] ? gen_count_q : gen_next[GEN_W-1:0];
        if (!array_active || limit_hit) begin
          state_d    = ST_IDLE;
          run_done_d = 1'b1;
          stable_d   = !array_active;
        end else begin
          cmd_d      = PE_CMD_PROCESS;
          run_busy_d = 1'b1;
        end
      end

      ST_SCAN: begin
        rd_en     = 1'b1;
        rd_last_d = rd_last_q;
        if (rd_ready) begin
          if (rd_last_q) begin
            state_d   = ST_IDLE;
            rd_en     = 1'b0;
            rd_last_d = 1'b0;
          end else begin
            if (rd_col_q == CW'(COLS-1)) begin
              rd_col_d = '0;
              rd_row_d = rd_row_q + 1'b1;
            end else begin
              rd_col_d = rd_col_q + 1'b1;
            end
            rd_last_d = (rd_row_d == RW'(ROWS-1)) && (rd_col_d == CW'(COLS-1));
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  pe_onehot_dec #(.N(ROWS), .W(RW)) u_dec_wr_row (.idx(wr_row),   .en(wr_en), .onehot(rsel_i_d));
  pe_onehot_dec #(.N(COLS), .W(CW)) u_dec_wr_col (.idx(wr_col),   .en(wr_en), .onehot(csel_i_d));
  pe_onehot_dec #(.N(ROWS), .W(RW)) u_dec_rd_row (.idx(rd_row_d), .en(rd_en), .onehot(rsel_o_d));
  pe_onehot_dec #(.N(COLS), .W(CW)) u_dec_rd_col (.idx(rd_col_d), .en(rd_en), .onehot(csel_o_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= PE_CMD_NOP;
      rsel_i_q    <= '0;
      csel_i_q    <= '0;
      rsel_o_q    <= '0;
      csel_o_q    <= '0;
      gens_q      <= '0;
      gen_count_q <= '0;
      run_busy_q  <= 1'b0;
      run_done_q  <= 1'b0;
      stable_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsel_i_q    <= rsel_i_d;
      csel_i_q    <= csel_i_d;
      rsel_o_q    <= rsel_o_d;
      csel_o_q    <= csel_o_d;
      gens_q      <= gens_d;
      gen_count_q <= gen_count_d;
      run_busy_q  <= run_busy_d;
      run_done_q  <= run_done_d;
      stable_q    <= stable_d;
      rd_last_q   <= rd_last_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
    end
  end

  assign cmd       = cmd_q;
  assign rsel_i    = rsel_i_q;
  assign csel_i    = csel_i_q;
  assign rsel_o    = rsel_o_q;
  assign csel_o    = csel_o_q;
  assign run_busy  = run_busy_q;
  assign run_done  = run_done_q;
  assign stable    = stable_q;
  assign gen_count = gen_count_q;
  assign rd_valid  = (state_q == ST_SCAN);
  assign rd_data   = array_state;
  assign rd_row    = rd_row_q;
  assign rd_col    = rd_col_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - directed bench for pe_array_ctrl with an 8x8 Life array model
module tb_pe_array_ctrl;
  import pe_ctrl_pkg::*;

  localparam int R = 8;
  localparam int C = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [PE_CMD_BITS-1:0]   cmd;
  logic [R-1:0]             rsel_i, rsel_o;
  logic [C-1:0]             csel_i, csel_o;
  logic                     array_active;
  logic [PE_STATE_BITS-1:0] array_state;
  logic                     wr_valid, wr_ready;
  logic [2:0]               wr_row, wr_col;
  logic [PE_STATE_BITS-1:0] wr_state;
  logic                     run_start, run_busy, run_done, stable;
  logic [15:0]              run_gens, gen_count;
  logic                     rd_start, rd_valid, rd_ready, rd_last;
  logic [PE_STATE_BITS-1:0] rd_data;
  logic [2:0]               rd_row, rd_col;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pe_array_ctrl #(.ROWS(R), .COLS(C), .GEN_W(16)) dut (
    .clk(clk), .rst(rst), .cmd(cmd),
    .rsel_i(rsel_i), .csel_i(csel_i), .rsel_o(rsel_o), .csel_o(csel_o),
    .array_active(array_active), .array_state(array_state),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_state(wr_state), .run_start(run_start), .run_gens(run_gens),
    .run_busy(run_busy), .run_done(run_done), .stable(stable), .gen_count(gen_count),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_row(rd_row), .rd_col(rd_col), .rd_last(rd_last)
  );

  // Behavioural PE array: bit r*8+c is cell (r,c); edges are permanently dead.
  logic [63:0] grid, nxt;

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] res;
    int n, rr, cc;
    res = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < R && cc >= 0 && cc < C)
              n += int'(g[rr*C+cc]);
          end
        end
        res[r*C+c] = g[r*C+c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return res;
  endfunction

  always_comb begin
    nxt          = life_next(grid);
    array_active = (cmd == PE_CMD_PROCESS) && (nxt != grid);
    array_state  = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (rsel_o[r] && csel_o[c]) array_state = array_state | grid[r*C+c];
  end

  always @(posedge clk) begin
    if (rst) begin
      grid <= '0;
    end else if (cmd == PE_CMD_WRITE) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          if (rsel_i[r] && csel_i[c]) grid[r*C+c] <= wr_state;
    end else if (cmd == PE_CMD_PROCESS) begin
      grid <= nxt;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_write(input int r, input int c, input logic v);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_row   = 3'(r);
    wr_col   = 3'(c);
    wr_state = v;
    check_eq("wr_ready_idle", 64'(wr_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    check_eq("wr_cmd", 64'(cmd), 64'(PE_CMD_WRITE));
    check_eq("wr_ready_busy", 64'(wr_ready), 64'd0);
    check_eq("wr_rsel", 64'(rsel_i), 64'(1) << r);
    check_eq("wr_csel", 64'(csel_i), 64'(1) << c);
    @(posedge clk);
  endtask

  // done_at counts cycles after the run_start edge: PROCESS k is cycle k.
  task automatic do_run(input int gens, output int nproc, output int done_at);
    @(negedge clk);
    run_gens  = 16'(gens);
    run_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_start = 1'b0;
    nproc     = 0;
    done_at   = -1;
    for (int k = 1; k <= 300; k++) begin
      if (cmd == PE_CMD_PROCESS) nproc++;
      if (run_done) begin
        done_at = k;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("run_busy_at_done", 64'(run_busy), 64'd0);
  endtask

  task automatic do_scan(input bit toggle, output logic [63:0] img);
    logic [3:0] pat;
    int beat, errs, last_cnt, last_pos, i;
    pat = 4'b1001;
    img = '0;
    beat = 0; errs = 0; last_cnt = 0; last_pos = -1; i = 0;
    @(negedge clk);
    rd_start = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd_start = 1'b0;
    check_eq("rd_valid_first", 64'(rd_valid), 64'd1);
    while (beat < 64 && i < 400) begin
      rd_ready = toggle ? pat[i%4] : 1'b1;
      if (!rd_valid || int'(rd_row) != beat / 8 || int'(rd_col) != beat % 8 ||
          rd_last != (beat == 63)) errs++;
      if (rd_ready) begin
        if (rd_last) begin
          last_cnt++;
          last_pos = beat;
        end
        img[beat] = rd_data;
        beat++;
      end
      @(posedge clk);
      @(negedge clk);
      i++;
    end
    rd_ready = 1'b0;
    check_eq("scan_beats", 64'(beat), 64'd64);
    check_eq("scan_coord_errs", 64'(errs), 64'd0);
    check_eq("scan_last_cnt", 64'(last_cnt), 64'd1);
    check_eq("scan_last_pos", 64'(last_pos), 64'd63);
    check_eq("scan_idle_after", 64'(rd_valid), 64'd0);
  endtask

  logic [63:0] img;
  int nproc, done_at, cnt, seen;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_state = '0;
    run_start = 1'b0; run_gens = '0; rd_start = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd", 64'(cmd), 64'(PE_CMD_NOP));
    check_eq("rst_sels", 64'({rsel_i, csel_i, rsel_o, csel_o}), 64'd0);
    check_eq("rst_flags", 64'({run_busy, run_done, stable, rd_valid, rd_last}), 64'd0);
    check_eq("rst_gen_count", 64'(gen_count), 64'd0);
    rst = 1'b0;

    // Single LIVE cell at (2,3).
    do_write(2, 3, PE_LIVE);
    do_scan(1'b0, img);
    check_eq("single_img", img, 64'h0000_0000_0008_0000);

    // Blinker, 4 generations returns to horizontal phase.
    do_reset();
    do_write(3, 2, PE_LIVE);
    do_write(3, 3, PE_LIVE);
    do_write(3, 4, PE_LIVE);
    do_run(4, nproc, done_at);
    check_eq("blink_nproc", 64'(nproc), 64'd4);
    check_eq("blink_done_at", 64'(done_at), 64'd5);
    check_eq("blink_gen_count", 64'(gen_count), 64'd4);
    check_eq("blink_stable", 64'(stable), 64'd0);
    do_scan(1'b1, img);
    check_eq("blink_img", img, 64'h0000_0000_1C00_0000);

    // Reset at generation 3 of a 10-generation run.
    @(negedge clk);
    run_gens = 16'd10;
    run_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 3; k++) begin
      if (cmd == PE_CMD_PROCESS) cnt++;
      if (cnt < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check_eq("rstrun_reached_gen3", 64'(cnt), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rstrun_cmd", 64'(cmd), 64'(PE_CMD_NOP));
    check_eq("rstrun_busy", 64'(run_busy), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (run_done) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("rstrun_no_done", 64'(seen), 64'd0);

    // 2x2 block is a still life.
    do_write(2, 2, PE_LIVE);
    do_write(2, 3, PE_LIVE);
    do_write(3, 2, PE_LIVE);
    do_write(3, 3, PE_LIVE);
    do_run(0, nproc, done_at);
    check_eq("block_nproc", 64'(nproc), 64'd1);
    check_eq("block_done_at", 64'(done_at), 64'd2);
    check_eq("block_stable", 64'(stable), 64'd1);
    check_eq("block_gen_count", 64'(gen_count), 64'd1);
    do_scan(1'b0, img);
    check_eq("block_img", img, 64'h0000_0000_0C0C_0000);

    // Empty array, unlimited and limit-1 runs both end stable.
    do_reset();
    do_run(0, nproc, done_at);
    check_eq("empty0_nproc", 64'(nproc), 64'd1);
    check_eq("empty0_stable", 64'(stable), 64'd1);
    check_eq("empty0_gen_count", 64'(gen_count), 64'd1);
    do_run(1, nproc, done_at);
    check_eq("empty1_nproc", 64'(nproc), 64'd1);
    check_eq("empty1_done_at", 64'(done_at), 64'd2);
    check_eq("empty1_stable", 64'(stable), 64'd1);

    // Simultaneous write, run and read requests: only the write proceeds.
    @(negedge clk);
    wr_valid = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_state = PE_LIVE;
    run_start = 1'b1; run_gens = 16'd5; rd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0; run_start = 1'b0; rd_start = 1'b0;
    check_eq("prio_cmd_write", 64'(cmd), 64'(PE_CMD_WRITE));
    check_eq("prio_no_busy", 64'(run_busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("prio_after_cmd", 64'(cmd), 64'(PE_CMD_NOP));
    check_eq("prio_after_busy", 64'(run_busy), 64'd0);
    check_eq("prio_after_rd", 64'(rd_valid), 64'd0);
    check_eq("prio_wr_ready", 64'(wr_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
